// File: rtl/rsa_precomp_ctrl_pkg.sv
// rsa_precomp_ctrl_pkg: shared FSM states, error codes and default parameters
// for the RSA CRT inverse precompute controller.
package rsa_precomp_ctrl_pkg;
    localparam int DEF_W       = 32;
    localparam int DEF_TIMEOUT = 96;
    typedef enum logic [2:0] {IDLE, CHECK, LOAD, RUN, STORE, DONE, ERR} state_e;
    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_GCD  = 2'b01;
    localparam logic [1:0] ERR_OPND = 2'b10;
    localparam logic [1:0] ERR_TMO  = 2'b11;
endpackage

// File: rtl/rsa_precomp_ctrl_inv_engine.sv
// inv_engine: extended Euclid, one quotient/remainder step per cycle; done fires on
// the step whose remainder is zero, with the current divisor as the gcd.
module inv_engine
    import rsa_precomp_ctrl_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         go_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] m_i,
    output logic         done_o,
    output logic [W:0]   result_o,
    output logic         gcd_one_o
);
    logic                run_q;
    logic [W-1:0]        or_q, r_q, div, quo, rem;
    logic signed [W:0]   os_q, s_q, s_n;
    always_comb begin
        div       = (r_q == '0) ? W'(1) : r_q;
        quo       = or_q / div;
        rem       = or_q % div;
        s_n       = os_q - $signed({1'b0, quo}) * s_q;
        done_o    = run_q && (rem == '0);
        gcd_one_o = (r_q == W'(1));
        result_o  = s_q;
    end
    // s tracks the Bezout coefficient of a for the current divisor r
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
            or_q  <= '0;
            r_q   <= '0;
            os_q  <= '0;
            s_q   <= '0;
        end else if (go_i) begin
            run_q <= 1'b1;
            or_q  <= a_i;
            r_q   <= m_i;
            os_q  <= (W+1)'(1);
            s_q   <= '0;
        end else if (run_q) begin
            if (rem == '0) begin
                run_q <= 1'b0;
            end else begin
                or_q <= r_q;
                r_q  <= rem;
                os_q <= s_q;
                s_q  <= s_n;
            end
        end
    end
endmodule

// File: rtl/rsa_precomp_ctrl.sv
// rsa_precomp_ctrl: computes qinv = q^-1 mod p and pinv = p^-1 mod q by running one
// shared inverse engine twice; results commit together only when both jobs succeed.
module rsa_precomp_ctrl
    import rsa_precomp_ctrl_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int W       = DEF_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [W-1:0] p_i,
    input  logic [W-1:0] q_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         err_o,
    output logic [1:0]   err_code_o,
    output logic [W-1:0] qinv_o,
    output logic [W-1:0] pinv_o
);
    localparam int CW = $clog2(TIMEOUT + 1);
    state_e         state_q, state_d;
    logic [W-1:0]   p_q, q_q, qtmp_q, qinv_q, pinv_q;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [1:0]     code_q, code_d;
    logic           job_q, job_d, eng_go, eng_done, eng_gcd1, bad_opnd;
    logic [W-1:0]   eng_a, eng_m, norm;
    logic [W:0]     eng_res;
    assign eng_a    = job_q ? p_q : q_q;
    assign eng_m    = job_q ? q_q : p_q;
    assign norm     = eng_res[W] ? eng_res[W-1:0] + eng_m : eng_res[W-1:0];
    assign bad_opnd = (p_q < W'(2)) || (q_q < W'(2)) || (p_q == q_q);
    inv_engine #(.W(W)) u_eng (
        .clk      (clk),
        .rst_n    (rst_n),
        .go_i     (eng_go),
        .a_i      (eng_a),
        .m_i      (eng_m),
        .done_o   (eng_done),
        .result_o (eng_res),
        .gcd_one_o(eng_gcd1)
    );
    always_comb begin
        state_d = state_q;
        job_d   = job_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        eng_go  = 1'b0;
        case (state_q)
            IDLE: if (start_i) begin
                state_d = CHECK;
                code_d  = ERR_NONE;
                job_d   = 1'b0;
            end
            CHECK: begin
                state_d = bad_opnd ? ERR : LOAD;
                code_d  = bad_opnd ? ERR_OPND : code_q;
            end
            LOAD: begin
                eng_go  = 1'b1;
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: if (eng_done) begin
                state_d = STORE;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                state_d = ERR;
                code_d  = ERR_TMO;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            STORE: if (!eng_gcd1) begin
                state_d = ERR;
                code_d  = ERR_GCD;
            end else begin
                state_d = job_q ? DONE : LOAD;
                job_d   = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            job_q   <= 1'b0;
            cnt_q   <= '0;
            code_q  <= ERR_NONE;
        end else begin
            state_q <= state_d;
            job_q   <= job_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
        end
    end
    // qinv is staged in qtmp so a failed J1 never exposes a half-updated pair
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q    <= '0;
            q_q    <= '0;
            qtmp_q <= '0;
            qinv_q <= '0;
            pinv_q <= '0;
        end else begin
            if (state_q == IDLE && start_i) begin
                p_q <= p_i;
                q_q <= q_i;
            end
            if (state_q == STORE && eng_gcd1) begin
                if (job_q) begin
                    qinv_q <= qtmp_q;
                    pinv_q <= norm;
                end else begin
                    qtmp_q <= norm;
                end
            end
        end
    end
    assign busy_o     = (state_q != IDLE);
    assign done_o     = (state_q == DONE);
    assign err_o      = (state_q == ERR);
    assign err_code_o = code_q;
    assign qinv_o     = qinv_q;
    assign pinv_o     = pinv_q;
endmodule

// File: tb/tb_rsa_precomp_ctrl.sv
// tb_rsa_precomp_ctrl: randomized bench; two DUTs (default and TIMEOUT=4) share stimulus
// and are compared against a number-theoretic reference model.
module tb_rsa_precomp_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] p_in = '0, q_in = '0;
    logic        busy[2], done[2], err[2];
    logic [1:0]  code[2];
    logic [31:0] qinv[2], pinv[2];
    int          checks = 0, errors = 0;
    longint      exp_q[2], exp_p[2];

    always #5 clk = ~clk;

    rsa_precomp_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .p_i(p_in), .q_i(q_in),
        .busy_o(busy[0]), .done_o(done[0]), .err_o(err[0]), .err_code_o(code[0]),
        .qinv_o(qinv[0]), .pinv_o(pinv[0])
    );
    rsa_precomp_ctrl #(.TIMEOUT(4)) dut_t (
        .clk(clk), .rst_n(rst_n), .start_i(start), .p_i(p_in), .q_i(q_in),
        .busy_o(busy[1]), .done_o(done[1]), .err_o(err[1]), .err_code_o(code[1]),
        .qinv_o(qinv[1]), .pinv_o(pinv[1])
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int div_steps(input longint a, input longint m);
        int n = 0;
        longint r;
        forever begin
            n++;
            r = a % m;
            if (r == 0) return n;
            a = m;
            m = r;
        end
    endfunction

    function automatic longint gcd(input longint a, input longint b);
        return (b == 0) ? a : gcd(b, a % b);
    endfunction

    function automatic longint modinv(input longint a, input longint m);
        longint t = 0, nt = 1, r = m, nr = a % m, qq, tmp;
        while (nr != 0) begin
            qq = r / nr;
            tmp = nt; nt = t - qq * nt; t = tmp;
            tmp = nr; nr = r - qq * nr; r = tmp;
        end
        return (t < 0) ? t + m : t;
    endfunction

    // outcome of one request: error code (0 = success) and cycle index of the done/err pulse,
    // counting the cycle in which start is sampled as cycle 0
    task automatic predict(input longint p, input longint q, input int to,
                           output int ecode, output int ecyc);
        int k0, k1;
        if (p < 2 || q < 2 || p == q) begin
            ecode = 2; ecyc = 2;
        end else begin
            k0 = div_steps(q, p);
            if (k0 > to) begin
                ecode = 3; ecyc = 3 + to;
            end else if (gcd(p, q) != 1) begin
                ecode = 1; ecyc = 4 + k0;
            end else begin
                k1 = div_steps(p, q);
                if (k1 > to) begin
                    ecode = 3; ecyc = 5 + k0 + to;
                end else begin
                    ecode = 0; ecyc = (2 + 2 * 2 + k0 + k1 + 1) - 1;
                end
            end
        end
    endtask

    task automatic run(input logic [31:0] pp, input logic [31:0] qq);
        int ecode[2], ecyc[2], fcyc[2];
        bit fin[2], ferr[2];
        logic [1:0] fcode[2];
        logic [31:0] fq[2], fp[2];
        for (int i = 0; i < 2; i++) begin
            predict(longint'(pp), longint'(qq), i ? 4 : 96, ecode[i], ecyc[i]);
            if (ecode[i] == 0) begin
                exp_q[i] = modinv(longint'(qq), longint'(pp));
                exp_p[i] = modinv(longint'(pp), longint'(qq));
            end
            fin[i] = 1'b0; fcyc[i] = 0;
        end
        @(negedge clk);
        p_in = pp; q_in = qq; start = 1'b1;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            start = 1'b0;
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("d%0d_dual", i), done[i] & err[i], 0);
                if (!fin[i] && (done[i] || err[i])) begin
                    fin[i] = 1'b1; fcyc[i] = c; ferr[i] = err[i];
                    fcode[i] = code[i]; fq[i] = qinv[i]; fp[i] = pinv[i];
                end else if (!fin[i]) begin
                    chk($sformatf("d%0d_busy", i), busy[i], 1);
                end else if (c == fcyc[i] + 1) begin
                    chk($sformatf("d%0d_pulse_end", i), {busy[i], done[i], err[i]}, 0);
                end
            end
            if (fin[0] && fin[1] && c > fcyc[0] && c > fcyc[1]) break;
        end
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("d%0d_finished", i), fin[i], 1);
            chk($sformatf("d%0d_is_err", i), ferr[i], ecode[i] != 0);
            chk($sformatf("d%0d_code", i), fcode[i], ecode[i]);
            chk($sformatf("d%0d_lat", i), fcyc[i], ecyc[i]);
            chk($sformatf("d%0d_qinv", i), fq[i], exp_q[i]);
            chk($sformatf("d%0d_pinv", i), fp[i], exp_p[i]);
        end
    endtask

    initial begin
        int ecode, ecyc, period, nd, last, sel;
        logic [31:0] rp, rq;
        exp_q = '{0, 0}; exp_p = '{0, 0};
        #12;
        for (int i = 0; i < 2; i++)
            chk($sformatf("d%0d_reset", i),
                {busy[i], done[i], err[i], code[i], qinv[i], pinv[i]}, 0);
        @(posedge clk); #2 rst_n = 1'b1;
        run(11, 7);
        chk("known_qinv", qinv[0], 8);
        chk("known_pinv", pinv[0], 2);
        run(12, 8);
        run(1, 7);
        run(32'hFFFF_FFFB, 32'h9E37_79B1);
        for (int n = 0; n < 24; n++) begin
            sel = $urandom_range(0, 3);
            rp = $urandom; rq = $urandom;
            case (sel)
                0: begin rp = $urandom_range(0, 20); rq = $urandom_range(0, 20); end
                2: rq = rp;
                3: rp = $urandom_range(0, 40);
                default: ;
            endcase
            run(rp, rq);
        end
        // start held high: one run per IDLE visit, requests during busy ignored
        predict(11, 7, 96, ecode, ecyc);
        period = ecyc + 1; nd = 0; last = 0;
        @(negedge clk);
        p_in = 11; q_in = 7; start = 1'b1;
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            chk("held_err", err[0], 0);
            if (done[0]) begin
                if (nd == 0) chk("held_first", c, ecyc);
                else chk("held_gap", c - last, period);
                chk("held_qinv", qinv[0], 8);
                nd++; last = c;
            end
        end
        chk("held_runs", nd, (70 - ecyc) / period + 1);
        start = 1'b0;
        for (int c = 0; c < 300 && (busy[0] || busy[1]); c++) @(negedge clk);
        chk("held_idle", busy[0] | busy[1], 0);
        exp_q[0] = 8; exp_p[0] = 2;
        // reset in the middle of a job
        @(negedge clk);
        p_in = 11; q_in = 7; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++)
            chk($sformatf("d%0d_midrst", i),
                {busy[i], done[i], err[i], code[i], qinv[i], pinv[i]}, 0);
        exp_q = '{0, 0}; exp_p = '{0, 0};
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++)
                chk($sformatf("d%0d_post_rst", i), {busy[i], done[i], err[i]}, 0);
        end
        run(11, 7);
        chk("rerun_qinv", qinv[0], 8);
        chk("rerun_pinv", pinv[0], 2);
        run(7, 11);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rsa_precomp_ctrl.md
RSA_PRECOMP_CTRL -- requirements
Module: rsa_precomp_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 96: maximum cycles allowed per inversion job before abort.
REQ-002 SHALL have parameter W, default 32: operand/result width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request new precompute; sampled only in IDLE.
REQ-006 p  input  W  prime p, sampled on accepted start.
REQ-007 q  input  W  prime q, sampled on accepted start.
REQ-008 busy  output  1  high from the cycle after accepted start until DONE/ERR exit.
REQ-009 done  output  1  one-cycle pulse, results valid.
REQ-010 err  output  1  one-cycle pulse, job aborted.
REQ-011 err_code  output  2  01 gcd≠1, 10 invalid operands, 11 timeout; held until next accepted start.
REQ-012 qinv  output  W  q^-1 mod p, in [1,p-1].
REQ-013 pinv  output  W  p^-1 mod q, in [1,q-1].

Function
REQ-014 SHALL sequence one shared inverse engine through two jobs: J0 (a=q, m=p -> qinv), then J1 (a=p, m=q -> pinv).
REQ-015 SHALL use states IDLE, CHECK, LOAD, RUN, STORE, DONE, ERR.
REQ-016 IDLE: start=1 -> latch p,q into internal registers, go CHECK; start=0 -> stay.
REQ-017 CHECK (1 cycle): p<2, q<2 or p==q -> ERR with code 10; else LOAD with job index 0.
REQ-018 LOAD (1 cycle): drive engine a/m from job index, pulse engine go, clear timeout counter, go RUN.
REQ-019 RUN: counter increments each cycle; engine done -> STORE; counter reaching TIMEOUT-1 without engine done -> ERR code 11.
REQ-020 STORE: engine gcd_one=0 -> ERR code 01; else write result to qinv (job 0) or pinv (job 1); job 0 -> LOAD job 1; job 1 -> DONE.
REQ-021 Engine result SHALL be normalised into [0,m-1]: negative Bezout coefficient (two's complement, MSB set) has m added before storing.
REQ-022 DONE: assert done for exactly one cycle, return to IDLE.
REQ-023 ERR: assert err for exactly one cycle, return to IDLE; qinv/pinv keep values of the last successful run, except a partially written qinv from the failed run SHALL be discarded (results commit together on J1 STORE).
REQ-024 start while busy SHALL be ignored, no queueing; start in DONE/ERR cycle ignored.
REQ-025 done and err SHALL never be high in the same cycle.
REQ-026 Latency: accepted start to done = 2 + 2*(2 + engine cycles) + 1 cycles; engine bounded by TIMEOUT.
REQ-027 Engine SHALL perform one Euclid quotient/remainder step per cycle, terminate when remainder reaches 0, report gcd_one = (final divisor == 1).
REQ-028 Arithmetic inside engine SHALL use W+1-bit signed Bezout coefficients to avoid overflow.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, busy=0, done=0, err=0, err_code=00, qinv=0, pinv=0, counter=0, engine idle.
REQ-030 Reset mid-job SHALL discard all partial results; no done/err pulse on release.
REQ-031 First accepted start SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-032 Shared package SHALL hold state enum, err_code constants (ERR_NONE, ERR_GCD, ERR_OPND, ERR_TMO), default W and TIMEOUT.
REQ-033 SHALL instantiate exactly one sub-module, inv_engine (ports: clk, rst_n, go, a, m, done, result, gcd_one).
REQ-034 Controller SHALL contain no divider; all division resides in inv_engine.

Verification
REQ-035 p=11, q=7, start -> done pulse, qinv=8, pinv=2, err=0.
REQ-036 p=12, q=8 -> err pulse, err_code=01, qinv/pinv unchanged from prior run.
REQ-037 p=1, q=7 -> err pulse two cycles after start, err_code=10, engine never started.
REQ-038 TIMEOUT=4, p=0xFFFFFFFB, q=0x9E3779B1 -> err_code=11 during J0.
REQ-039 p=11, q=7, rst_n low 3 cycles after start -> all outputs 0, IDLE, no pulses; new start then yields qinv=8, pinv=2.
REQ-040 start held high continuously with p=11, q=7 -> one run per IDLE entry, start during busy ignored, done every run.
